sample_ctrl: RTL and testbench

SAMPLE_CTRL -- requirements
Module: sample_ctrl

---
 rtl/sample_ctrl_if.sv | 30 +++
 rtl/sample_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sample_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_ctrl_if.sv
// Sample controller handshake bundle: sample/overflow/clear requests toward the
// controller and the datapath control strobes coming back from it.
interface sample_ctrl_if;
    logic       data_ready;
    logic       overflow;
    logic       window_clr;
    logic       modwait;
    logic       load_sample;
    logic       acc_clr;
    logic       mac_en;
    logic [3:0] tap_sel;
    logic       result_valid;
    logic       err;
    logic       overrun;
    logic       one_k_samples;

    // Sample source / datapath side that drives requests
    modport master (
        output data_ready, overflow, window_clr,
        input  modwait, load_sample, acc_clr, mac_en, tap_sel,
               result_valid, err, overrun, one_k_samples
    );

    // Controller side
    modport slave (
        input  data_ready, overflow, window_clr,
        output modwait, load_sample, acc_clr, mac_en, tap_sel,
               result_valid, err, overrun, one_k_samples
    );
endinterface

// File: rtl/sample_ctrl.sv
// Sample-processing controller for a MAC filter datapath.
// Each accepted sample runs LOAD (1 cycle), MAC (NUM_TAPS cycles), OUT (1 cycle).
// One extra sample can be queued while busy; a further one is dropped and flagged.
// A wrapping sample counter flags when WINDOW samples have been loaded.
module sample_ctrl #(
    parameter int NUM_TAPS = 4,
    parameter int WINDOW   = 1000,
    parameter int CNT_BITS = 10
) (
    input  logic         clk,
    input  logic         rst,
    sample_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT,
        S_ERR
    } state_t;

    localparam logic [3:0]          LAST_TAP = 4'(NUM_TAPS - 1);
    localparam logic [CNT_BITS-1:0] WIN_CNT  = CNT_BITS'(WINDOW);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    state_t              state_q, state_d;
    logic [3:0]          tap_q, tap_d;
    logic                pending_q, pending_d;
    logic                overrun_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                modwait_q;
    logic                load_sample_q;
    logic                acc_clr_q;
    logic                mac_en_q;
    logic [3:0]          tap_sel_q;
    logic                result_valid_q;
    logic                err_q;
    logic                overrun_q;
    logic                one_k_q;

    logic                busy;

    assign busy = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_OUT);

    // Next-state, tap index and pending/overrun bookkeeping
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        pending_d = pending_q;
        overrun_d = 1'b0;

        // A sample arriving while busy is queued once; a second one is dropped
        if (busy && bus.data_ready) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.data_ready || pending_q) begin
                    state_d   = S_LOAD;
                    // Queued sample is consumed; a fresh one arriving together stays queued
                    pending_d = pending_q & bus.data_ready;
                end
            end
            S_LOAD: begin
                state_d = S_MAC;
                tap_d   = 4'd0;
            end
            S_MAC: begin
                if (bus.overflow) begin
                    state_d = S_ERR;
                    tap_d   = 4'd0;
                end else if (tap_q == LAST_TAP) begin
                    state_d = S_OUT;
                    tap_d   = 4'd0;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_OUT: begin
                if (pending_q) begin
                    state_d   = S_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (bus.data_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                tap_d   = 4'd0;
            end
        endcase
    end

    // Window counter: clear wins over the per-LOAD increment, wrap goes to 1
    always_comb begin
        cnt_d = cnt_q;
        if (bus.window_clr) begin
            cnt_d = '0;
        end else if (state_q == S_LOAD) begin
            cnt_d = (cnt_q == WIN_CNT) ? CNT_ONE : (cnt_q + CNT_ONE);
        end
    end

    // FSM state plus Moore outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tap_q          <= 4'd0;
            pending_q      <= 1'b0;
            modwait_q      <= 1'b0;
            load_sample_q  <= 1'b0;
            acc_clr_q      <= 1'b0;
            mac_en_q       <= 1'b0;
            tap_sel_q      <= 4'd0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            pending_q      <= pending_d;
            modwait_q      <= (state_d == S_LOAD) || (state_d == S_MAC) || (state_d == S_OUT);
            load_sample_q  <= (state_d == S_LOAD);
            acc_clr_q      <= (state_d == S_LOAD);
            mac_en_q       <= (state_d == S_MAC);
            tap_sel_q      <= (state_d == S_MAC) ? tap_d : 4'd0;
            result_valid_q <= (state_d == S_OUT);
            err_q          <= (state_d == S_ERR);
            overrun_q      <= overrun_d;
        end
    end

    // Sample window count and its registered terminal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            one_k_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            one_k_q <= (cnt_d == WIN_CNT);
        end
    end

    assign bus.modwait       = modwait_q;
    assign bus.load_sample   = load_sample_q;
    assign bus.acc_clr       = acc_clr_q;
    assign bus.mac_en        = mac_en_q;
    assign bus.tap_sel       = tap_sel_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.err           = err_q;
    assign bus.overrun       = overrun_q;
    assign bus.one_k_samples = one_k_q;

endmodule

// File: tb/tb_sample_ctrl.sv
// Directed bench for sample_ctrl: per-cycle stimulus/expectation tables for the
// sample flow scenarios, plus a long run of samples for the window counter.
module tb_sample_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sample_ctrl_if bus ();

    sample_ctrl #(
        .NUM_TAPS (4),
        .WINDOW   (1000),
        .CNT_BITS (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks_cnt   = 0;
    int failures_cnt = 0;

    // Output vector: {modwait, load_sample, acc_clr, mac_en, tap_sel[3:0],
    //                 result_valid, err, overrun, one_k_samples}
    typedef struct packed {
        logic        rst;
        logic        dr;
        logic        ov;
        logic        wc;
        logic [11:0] exp;
    } step_t;

    step_t seq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] v(input logic mw, input logic ld, input logic ac,
                                       input logic me, input logic [3:0] tap,
                                       input logic rv, input logic er, input logic ovr,
                                       input logic ok);
        return {mw, ld, ac, me, tap, rv, er, ovr, ok};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.modwait, bus.load_sample, bus.acc_clr, bus.mac_en, bus.tap_sel,
                bus.result_valid, bus.err, bus.overrun, bus.one_k_samples};
    endfunction

    localparam logic [11:0] V_I = 12'h000;
    localparam logic [11:0] V_L = 12'b1110_0000_0000;
    localparam logic [11:0] V_O = 12'b1000_0000_1000;
    localparam logic [11:0] V_E = 12'b0000_0000_0100;

    function automatic logic [11:0] vm(input int k);
        return v(1'b1, 1'b0, 1'b0, 1'b1, 4'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic add(input logic r, input logic dr, input logic ov, input logic wc,
                       input logic [11:0] exp);
        step_t s;
        s.rst = r; s.dr = dr; s.ov = ov; s.wc = wc; s.exp = exp;
        seq.push_back(s);
    endtask

    task automatic add_mac();
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, vm(k));
    endtask

    // Each entry: check outputs of this cycle, then drive this cycle's inputs
    task automatic run_seq(input string name);
        foreach (seq[i]) begin
            check($sformatf("%s c%0d", name, i), {20'd0, obs()}, {20'd0, seq[i].exp});
            rst            = seq[i].rst;
            bus.data_ready = seq[i].dr;
            bus.overflow   = seq[i].ov;
            bus.window_clr = seq[i].wc;
            @(negedge clk);
        end
        $display("seq %s: %0d cycles checked", name, seq.size());
        seq.delete();
        rst            = 1'b0;
        bus.data_ready = 1'b0;
        bus.overflow   = 1'b0;
        bus.window_clr = 1'b0;
    endtask

    // One complete sample (LOAD..OUT) ending back in IDLE; optional clear on LOAD
    task automatic one_sample(input logic wc_on_load);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.window_clr = wc_on_load;
        @(negedge clk);
        bus.window_clr = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.data_ready = 1'b1;
        bus.overflow   = 1'b0;
        bus.window_clr = 1'b1;
        @(negedge clk);

        // Reset with data_ready and window_clr also high: everything stays 0
        add(1, 1, 0, 1, V_I);
        add(0, 0, 0, 0, V_I);
        add(0, 0, 0, 0, V_I);
        run_seq("reset");

        // Single sample: LOAD at 1, taps 0..3 at 2..5, result at 6
        add(0, 1, 0, 0, V_I);
        add(0, 0, 0, 0, V_L);
        add_mac();
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_I);
        run_seq("single");

        // Back-to-back: second request at cycle 3 queued, LOAD right after OUT
        add(0, 1, 0, 0, V_I);
        add(0, 0, 0, 0, V_L);
        add(0, 0, 0, 0, vm(0));
        add(0, 1, 0, 0, vm(1));
        add(0, 0, 0, 0, vm(2));
        add(0, 0, 0, 0, vm(3));
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_L);
        add_mac();
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_I);
        run_seq("b2b");

        // Overrun: requests at 0, 3, 4 -> overrun at 5, two results only
        add(0, 1, 0, 0, V_I);
        add(0, 0, 0, 0, V_L);
        add(0, 0, 0, 0, vm(0));
        add(0, 1, 0, 0, vm(1));
        add(0, 1, 0, 0, vm(2));
        add(0, 0, 0, 0, vm(3) | 12'b0000_0000_0010);
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_L);
        add_mac();
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_I);
        add(0, 0, 0, 0, V_I);
        run_seq("overrun");

        // Overflow at tap 2 -> ERR, no result; next request restarts cleanly
        add(0, 1, 0, 0, V_I);
        add(0, 0, 0, 0, V_L);
        add(0, 0, 0, 0, vm(0));
        add(0, 0, 0, 0, vm(1));
        add(0, 0, 1, 0, vm(2));
        add(0, 0, 0, 0, V_E);
        add(0, 1, 0, 0, V_E);
        add(0, 0, 0, 0, V_L);
        add_mac();
        add(0, 0, 0, 0, V_O);
        add(0, 0, 0, 0, V_I);
        run_seq("error");

        // Reset at tap 1 with a queued sample: idle next cycle, queue dropped
        add(0, 1, 0, 0, V_I);
        add(0, 0, 0, 0, V_L);
        add(0, 1, 0, 0, vm(0));
        add(1, 0, 0, 0, vm(1));
        add(0, 0, 0, 0, V_I);
        add(0, 0, 0, 0, V_I);
        add(0, 0, 0, 0, V_I);
        run_seq("rst_mac");

        // Window counter from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (999) one_sample(1'b0);
        check("win 999", {31'd0, bus.one_k_samples}, 32'd0);
        one_sample(1'b0);
        check("win 1000", {31'd0, bus.one_k_samples}, 32'd1);
        one_sample(1'b0);
        check("win 1001", {31'd0, bus.one_k_samples}, 32'd0);
        one_sample(1'b1);
        check("win clr", {31'd0, bus.one_k_samples}, 32'd0);
        repeat (999) one_sample(1'b0);
        check("win clr+999", {31'd0, bus.one_k_samples}, 32'd0);
        one_sample(1'b0);
        check("win clr+1000", {31'd0, bus.one_k_samples}, 32'd1);
        $display("seq window: done");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
